// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, follows the predictor, and loads the IF/ID register one cycle after lookup.
// A redirect squashes IF/ID and beats stall, which holds PC, IF/ID and counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] bp_pc,
    input  logic        bp_taken,
    input  logic [31:0] bp_target,
    input  logic [1:0]  bp_state,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_pred_taken,
    output logic [31:0] if_id_pred_target,
    output logic [1:0]  if_id_pred_state,
    output logic [31:0] perf_fetch_count,
    output logic [31:0] perf_redirect_count
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred_taken;
        logic [31:0] pred_target;
        logic [1:0]  pred_state;
    } if_id_t;

    logic [31:0] r_pc;
    logic        r_valid;
    if_id_t      r_if_id;
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_redir_cnt;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_pred_target;

    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_pred_target = bp_taken ? bp_target : w_pc_plus4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_valid     <= 1'b0;
            r_if_id     <= '0;
            r_fetch_cnt <= '0;
            r_redir_cnt <= '0;
        end else if (redirect_en) begin
            // IF/ID payload is left as-is; only the valid bit squashes it.
            r_pc    <= {redirect_pc[31:2], 2'b00};
            r_valid <= 1'b0;
            if (r_redir_cnt != 32'hFFFF_FFFF)
                r_redir_cnt <= r_redir_cnt + 32'd1;
        end else if (!stall) begin
            r_pc                <= {w_pred_target[31:2], 2'b00};
            r_valid             <= 1'b1;
            r_if_id.pc          <= r_pc;
            r_if_id.instr       <= imem_rdata;
            r_if_id.pred_taken  <= bp_taken;
            r_if_id.pred_target <= w_pred_target;
            r_if_id.pred_state  <= bp_state;
            if (r_fetch_cnt != 32'hFFFF_FFFF)
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    assign imem_addr           = r_pc;
    assign bp_pc               = r_pc;
    assign if_id_valid         = r_valid;
    assign if_id_pc            = r_if_id.pc;
    assign if_id_instr         = r_if_id.instr;
    assign if_id_pred_taken    = r_if_id.pred_taken;
    assign if_id_pred_target   = r_if_id.pred_target;
    assign if_id_pred_state    = r_if_id.pred_state;
    assign perf_fetch_count    = r_fetch_cnt;
    assign perf_redirect_count = r_redir_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential, reset, stall, redirect, wrap and async-reset cases.
module tb_fetch_stage;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] IMASK = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] bp_pc;
    logic        bp_taken;
    logic [31:0] bp_target;
    logic [1:0]  bp_state;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_pred_taken;
    logic [31:0] if_id_pred_target;
    logic [1:0]  if_id_pred_state;
    logic [31:0] perf_fetch_count;
    logic [31:0] perf_redirect_count;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Instruction memory model: word content derived from its address.
    assign imem_rdata = imem_addr ^ IMASK;

    fetch_stage #(.RESET_PC(RPC)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall               (stall),
        .redirect_en         (redirect_en),
        .redirect_pc         (redirect_pc),
        .imem_addr           (imem_addr),
        .imem_rdata          (imem_rdata),
        .bp_pc               (bp_pc),
        .bp_taken            (bp_taken),
        .bp_target           (bp_target),
        .bp_state            (bp_state),
        .if_id_valid         (if_id_valid),
        .if_id_pc            (if_id_pc),
        .if_id_instr         (if_id_instr),
        .if_id_pred_taken    (if_id_pred_taken),
        .if_id_pred_target   (if_id_pred_target),
        .if_id_pred_state    (if_id_pred_state),
        .perf_fetch_count    (perf_fetch_count),
        .perf_redirect_count (perf_redirect_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"},      imem_addr, RPC);
        check({tag, "_bp_pc"},   bp_pc, RPC);
        check({tag, "_valid"},   {31'd0, if_id_valid}, 32'd0);
        check({tag, "_ifpc"},    if_id_pc, 32'd0);
        check({tag, "_instr"},   if_id_instr, 32'd0);
        check({tag, "_ptaken"},  {31'd0, if_id_pred_taken}, 32'd0);
        check({tag, "_ptarget"}, if_id_pred_target, 32'd0);
        check({tag, "_pstate"},  {30'd0, if_id_pred_state}, 32'd0);
        check({tag, "_fcnt"},    perf_fetch_count, 32'd0);
        check({tag, "_rcnt"},    perf_redirect_count, 32'd0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
        bp_taken = 1'b0; bp_target = '0; bp_state = 2'b00;
        #3;
        check_reset_state("rst0");

        // Sequential fetch from RESET_PC.
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("seq_ifpc",  if_id_pc, RPC + 32'(4 * k));
            check("seq_valid", {31'd0, if_id_valid}, 32'd1);
        end
        check("seq_instr",  if_id_instr, 32'h0000_010C ^ IMASK);
        check("seq_fcnt",   perf_fetch_count, 32'd4);
        check("seq_pc",     imem_addr, 32'h0000_0110);
        check("seq_ptgt",   if_id_pred_target, 32'h0000_0110);

        // Taken prediction into 0x120.
        bp_taken = 1'b1; bp_target = 32'h0000_0120; bp_state = 2'b10;
        tick();
        check("tk1_pc",     imem_addr, 32'h0000_0120);
        check("tk1_ifpc",   if_id_pc, 32'h0000_0110);
        check("tk1_ptaken", {31'd0, if_id_pred_taken}, 32'd1);
        check("tk1_pstate", {30'd0, if_id_pred_state}, 32'd2);

        // Stall three cycles at pc 0x120.
        bp_taken = 1'b0; bp_state = 2'b01; stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stl_pc",     imem_addr, 32'h0000_0120);
            check("stl_ifpc",   if_id_pc, 32'h0000_0110);
            check("stl_ptaken", {31'd0, if_id_pred_taken}, 32'd1);
            check("stl_ptgt",   if_id_pred_target, 32'h0000_0120);
            check("stl_pstate", {30'd0, if_id_pred_state}, 32'd2);
            check("stl_fcnt",   perf_fetch_count, 32'd5);
        end
        stall = 1'b0;
        tick();
        check("rel_ifpc",   if_id_pc, 32'h0000_0120);
        check("rel_instr",  if_id_instr, 32'h0000_0120 ^ IMASK);
        check("rel_pstate", {30'd0, if_id_pred_state}, 32'd1);
        check("rel_fcnt",   perf_fetch_count, 32'd6);

        // Unaligned predicted target: pc masked, recorded target kept raw.
        bp_taken = 1'b1; bp_target = 32'h0000_0202; bp_state = 2'b10;
        tick();
        check("ua_pc",   imem_addr, 32'h0000_0200);
        check("ua_ptgt", if_id_pred_target, 32'h0000_0202);

        bp_target = 32'h0000_0240; bp_state = 2'b11;
        tick();
        check("tk2_pc",     imem_addr, 32'h0000_0240);
        check("tk2_ifpc",   if_id_pc, 32'h0000_0200);
        check("tk2_ptaken", {31'd0, if_id_pred_taken}, 32'd1);
        check("tk2_ptgt",   if_id_pred_target, 32'h0000_0240);
        check("tk2_pstate", {30'd0, if_id_pred_state}, 32'd3);

        // Redirect with stall in the same cycle.
        bp_taken = 1'b0; bp_state = 2'b00;
        redirect_en = 1'b1; redirect_pc = 32'h0000_0403; stall = 1'b1;
        tick();
        check("rd_pc",    imem_addr, 32'h0000_0400);
        check("rd_valid", {31'd0, if_id_valid}, 32'd0);
        check("rd_rcnt",  perf_redirect_count, 32'd1);
        check("rd_fcnt",  perf_fetch_count, 32'd8);
        check("rd_ifpc",  if_id_pc, 32'h0000_0200);
        redirect_en = 1'b0; stall = 1'b0;
        tick();
        check("rd2_ifpc",  if_id_pc, 32'h0000_0400);
        check("rd2_valid", {31'd0, if_id_valid}, 32'd1);
        check("rd2_fcnt",  perf_fetch_count, 32'd9);

        // Back-to-back redirects, landing on the top word.
        redirect_en = 1'b1; redirect_pc = 32'h0000_0800;
        tick();
        check("rr1_pc",    imem_addr, 32'h0000_0800);
        redirect_pc = 32'hFFFF_FFFF;
        tick();
        check("rr2_pc",    imem_addr, 32'hFFFF_FFFC);
        check("rr2_valid", {31'd0, if_id_valid}, 32'd0);
        check("rr2_rcnt",  perf_redirect_count, 32'd3);
        redirect_en = 1'b0;
        tick();
        check("wrap_pc",   imem_addr, 32'h0000_0000);
        check("wrap_ifpc", if_id_pc, 32'hFFFF_FFFC);
        check("wrap_ptgt", if_id_pred_target, 32'h0000_0000);
        check("wrap_fcnt", perf_fetch_count, 32'd10);

        // Asynchronous reset mid-stream, with a redirect pending.
        tick();
        check("pre_valid", {31'd0, if_id_valid}, 32'd1);
        redirect_en = 1'b1; redirect_pc = 32'h0000_0900;
        #2 rst = 1'b1;
        #1;
        check_reset_state("arst");
        @(negedge clk);
        rst = 1'b0; redirect_en = 1'b0;
        tick();
        check("post_ifpc",  if_id_pc, RPC);
        check("post_valid", {31'd0, if_id_valid}, 32'd1);
        check("post_fcnt",  perf_fetch_count, 32'd1);
        check("post_rcnt",  perf_redirect_count, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage RISC-V pipeline. It owns the program counter, drives the instruction-memory address and the branch predictor's lookup PC, and chooses next-PC from the predictor output. It registers the fetched instruction and its prediction metadata into the IF/ID pipeline register. It accepts stalls from hazard control and redirects from ID-stage branch resolution on mispredict, and keeps fetch/redirect performance counters.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- stall  in  1  hazard stall; hold PC and IF/ID
- redirect_en  in  1  ID-stage mispredict; squash and refetch
- redirect_pc  in  32  correct PC on redirect (bits [1:0] ignored, treated as 0)
- imem_addr  out  32  instruction memory address (= pc)
- imem_rdata  in  32  instruction word, combinational from imem_addr
- bp_pc  out  32  predictor lookup PC (= pc)
- bp_taken  in  1  predictor says taken
- bp_target  in  32  predicted target (pc+4 on BTB miss)
- bp_state  in  2  predictor 2-bit counter state for this PC
- if_id_valid  out  1  IF/ID holds a live instruction
- if_id_pc  out  32  PC of instruction in IF/ID
- if_id_instr  out  32  instruction word
- if_id_pred_taken  out  1  prediction used at fetch
- if_id_pred_target  out  32  predicted target used at fetch
- if_id_pred_state  out  2  counter state, returned later as resolved_state
- perf_fetch_count  out  32  instructions written into IF/ID valid
- perf_redirect_count  out  32  redirects accepted

## Operation
- State: pc register, IF/ID register (valid + 5 fields), two counters.
- Per-cycle priority: redirect_en > stall > normal advance.
- Redirect (redirect_en=1, stall ignored): pc <= {redirect_pc[31:2],2'b00}; if_id_valid <= 0; other IF/ID fields hold; perf_redirect_count += 1.
- Stall (stall=1, redirect_en=0): pc, all IF/ID fields, counters hold.
- Advance: pc <= bp_taken ? {bp_target[31:2],2'b00} : pc+4; if_id_valid <= 1; if_id_pc <= pc; if_id_instr <= imem_rdata; if_id_pred_taken <= bp_taken; if_id_pred_target <= bp_taken ? bp_target : pc+4; if_id_pred_state <= bp_state; perf_fetch_count += 1.
- pc+4 is 32-bit modulo: 0xFFFF_FFFC advances to 0x0000_0000.
- Counters saturate at 0xFFFF_FFFF (no wrap).
- imem_addr and bp_pc are direct combinational copies of pc; no other combinational path from inputs to outputs.

## Timing
- Reset (async assert, sync to outputs immediately): pc=RESET_PC, imem_addr=bp_pc=RESET_PC, if_id_valid=0, if_id_pc=0, if_id_instr=0, if_id_pred_taken=0, if_id_pred_target=0, if_id_pred_state=0, both counters 0.
- Reset mid-operation discards IF/ID contents and in-flight redirect; first edge after deassertion captures instruction at RESET_PC.
- Fetch latency: 1 cycle, pc at edge N appears as if_id_pc after edge N.
- Redirect: bubble of exactly 1 cycle; instruction at redirect_pc is in IF/ID (valid) after the second edge from redirect assertion, absent stall.
- redirect_en and stall both high: redirect taken, stall has no effect that cycle.
- Consecutive redirects: each one overwrites pc; if_id_valid stays 0; counter increments per cycle.
- Stall held N cycles: outputs identical for N cycles; advance resumes with the held pc re-looked-up (predictor output may differ if updated meanwhile).

## Test plan
- Reset RESET_PC=0x100, no stall, bp_taken=0, 4 cycles -> if_id_pc 0x100,0x104,0x108,0x10C, valid=1, perf_fetch_count=4.
- At pc=0x200, bp_taken=1, bp_target=0x240, bp_state=2'b11 -> next pc 0x240; IF/ID shows pc 0x200, pred_taken=1, pred_target=0x240, pred_state=3.
- stall=1 for 3 cycles at pc=0x120 -> pc and all IF/ID fields unchanged, perf_fetch_count unchanged; release -> if_id_pc 0x120.
- redirect_en=1, redirect_pc=0x403, stall=1 same cycle -> pc=0x400, if_id_valid=0 next cycle, perf_redirect_count=1; following cycle if_id_pc=0x400 valid.
- pc=0xFFFF_FFFC, bp_taken=0 -> next pc 0x0000_0000.
- Assert rst asynchronously mid-stream with valid IF/ID -> all outputs return to reset values before next clk edge.
